// File: rtl/mem_arbiter.sv
// Shares one external memory port between the fetch (imem) and load/store (dmem) paths.
// One pending request per side, one transaction in flight, data priority with a fetch-starvation bound.
module mem_arbiter #(
    parameter int unsigned MAX_DBURST = 4
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        iflush,

    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,

    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_e;

    localparam logic [3:0] MAX_CNT = 4'(MAX_DBURST);

    state_e      state_q, state_d;
    logic        i_pend_q, i_pend_d;
    logic [31:0] i_addr_q, i_addr_d;
    logic        d_pend_q, d_pend_d;
    logic [31:0] d_addr_q, d_addr_d;
    logic [31:0] d_wdata_q, d_wdata_d;
    logic [3:0]  d_wstrb_q, d_wstrb_d;
    logic        drop_q, drop_d;
    logic [3:0]  dcount_q, dcount_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_instr_q, mem_instr_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;

    logic        i_owned, i_accept, i_keep, i_cand;
    logic        d_owned, d_accept, d_cand;
    logic        decide, grant_i, grant_d;
    logic [31:0] i_cand_addr, d_cand_addr, d_cand_wdata;
    logic [3:0]  d_cand_wstrb;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        // A side is busy while it has a pending slot or a live grant not yet completing;
        // a dropped fetch no longer owns the imem side, and a flush frees it for the new target.
        i_owned  = !iflush && (i_pend_q || (state_q == IBUSY && !drop_q && !mem_ready));
        i_accept = imem_valid && !i_owned;
        i_keep   = i_pend_q && !iflush;
        i_cand   = i_keep || i_accept;
        i_cand_addr = i_keep ? i_addr_q : imem_addr;

        d_owned  = d_pend_q || (state_q == DBUSY && !mem_ready);
        d_accept = dmem_valid && !d_owned;
        d_cand   = d_pend_q || d_accept;
        d_cand_addr  = d_pend_q ? d_addr_q  : dmem_addr;
        d_cand_wdata = d_pend_q ? d_wdata_q : dmem_wdata;
        d_cand_wstrb = d_pend_q ? d_wstrb_q : dmem_wstrb;

        decide  = (state_q == IDLE) || mem_ready;
        grant_i = decide && i_cand && (!d_cand || dcount_q == MAX_CNT);
        grant_d = decide && d_cand && !grant_i;

        state_d     = state_q;
        i_pend_d    = i_cand && !grant_i;
        i_addr_d    = i_accept ? imem_addr : i_addr_q;
        d_pend_d    = d_cand && !grant_d;
        d_addr_d    = d_accept ? dmem_addr  : d_addr_q;
        d_wdata_d   = d_accept ? dmem_wdata : d_wdata_q;
        d_wstrb_d   = d_accept ? dmem_wstrb : d_wstrb_q;
        drop_d      = drop_q;
        dcount_d    = dcount_q;
        mem_valid_d = grant_i || grant_d;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;

        if (decide) begin
            if (grant_i)      state_d = IBUSY;
            else if (grant_d) state_d = DBUSY;
            else              state_d = IDLE;
        end

        if (grant_i) begin
            mem_instr_d = 1'b1;
            mem_addr_d  = i_cand_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
        end else if (grant_d) begin
            mem_instr_d = 1'b0;
            mem_addr_d  = d_cand_addr;
            mem_wdata_d = d_cand_wdata;
            mem_wstrb_d = d_cand_wstrb;
        end

        // A flushed fetch still completes on the bus; drop hides that one response.
        if (state_q == IBUSY && mem_ready)   drop_d = 1'b0;
        else if (state_q == IBUSY && iflush) drop_d = 1'b1;

        if (grant_i || !i_cand)                     dcount_d = '0;
        else if (grant_d && dcount_q != MAX_CNT)    dcount_d = dcount_q + 4'd1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            i_pend_q    <= 1'b0;
            i_addr_q    <= '0;
            d_pend_q    <= 1'b0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
            d_wstrb_q   <= '0;
            drop_q      <= 1'b0;
            dcount_q    <= '0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            i_pend_q    <= i_pend_d;
            i_addr_q    <= i_addr_d;
            d_pend_q    <= d_pend_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            d_wstrb_q   <= d_wstrb_d;
            drop_q      <= drop_d;
            dcount_q    <= dcount_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_instr  = mem_instr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;

    assign imem_ready = (state_q == IBUSY) && mem_ready && !drop_q;
    assign dmem_ready = (state_q == DBUSY) && mem_ready;
    assign imem_rdata = mem_rdata;
    assign dmem_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch/store issue, burst fairness, flush drop, reset abort, delayed response.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_valid = 1'b0, iflush = 1'b0, dmem_valid = 1'b0, mem_ready = 1'b0;
    logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
    logic [3:0]  dmem_wstrb = '0;
    logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
    logic        imem_ready, dmem_ready, mem_valid, mem_instr;
    logic [3:0]  mem_wstrb;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.MAX_DBURST(4)) dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ready(imem_ready), .iflush(iflush),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_wstrb(dmem_wstrb), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    // Requester-side protocol guard: no new pulse while that side still awaits its response.
    logic d_out, i_out;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= 1'b0;
            i_out <= 1'b0;
        end else begin
            if (dmem_valid)      d_out <= 1'b1;
            else if (dmem_ready) d_out <= 1'b0;
            if (imem_valid)                 i_out <= 1'b1;
            else if (imem_ready || iflush)  i_out <= 1'b0;
        end
    end
    always @(negedge clk) begin
        if (rst && dmem_valid && d_out && !dmem_ready) begin
            n_fail++; $display("FAIL protocol_dmem: pulse while outstanding at %0t", $time);
        end
        if (rst && imem_valid && i_out && !imem_ready && !iflush) begin
            n_fail++; $display("FAIL protocol_imem: pulse while outstanding at %0t", $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        imem_valid = 1'b0; dmem_valid = 1'b0; iflush = 1'b0;
        mem_ready  = 1'b0; mem_rdata  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(); tick();
        mem_ready = 1'b1;
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_valid: got %b want 0", mem_valid); end
        n_checks++; if (mem_instr !== 1'b0) begin n_fail++; $display("FAIL rst_mem_instr: got %b want 0", mem_instr); end
        n_checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_attr: got addr %h wdata %h want 0", mem_addr, mem_wdata); end
        n_checks++; if (mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL rst_mem_wstrb: got %h want 0", mem_wstrb); end
        n_checks++; if (imem_ready !== 1'b0 || dmem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got i %b d %b want 0 0", imem_ready, dmem_ready); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        tick(); imem_valid = 1'b1; imem_addr = 32'h100;
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_early: got %b want 0", mem_valid); end
        tick(); #1;
        n_checks++; if (mem_valid !== 1'b1 || mem_instr !== 1'b1) begin n_fail++; $display("FAIL fetch_issue: got v %b i %b want 1 1", mem_valid, mem_instr); end
        n_checks++; if (mem_addr !== 32'h100 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL fetch_attr: got %h/%h want 00000100/0", mem_addr, mem_wstrb); end
        tick(); mem_ready = 1'b1; mem_rdata = 32'h13;
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_pulse_len: got %b want 0", mem_valid); end
        n_checks++; if (imem_ready !== 1'b1 || imem_rdata !== 32'h13) begin n_fail++; $display("FAIL fetch_resp: got %b %h want 1 00000013", imem_ready, imem_rdata); end
        n_checks++; if (dmem_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_dready: got %b want 0", dmem_ready); end
        tick(); #1;
        n_checks++; if (mem_valid !== 1'b0 || imem_ready !== 1'b0) begin n_fail++; $display("FAIL fetch_idle: got v %b r %b want 0 0", mem_valid, imem_ready); end
    endtask

    task automatic test_simultaneous();
        tick();
        imem_valid = 1'b1; imem_addr = 32'h200;
        dmem_valid = 1'b1; dmem_addr = 32'h8000; dmem_wdata = 32'hDEADBEEF; dmem_wstrb = 4'hF;
        tick(); #1;
        n_checks++; if (mem_valid !== 1'b1 || mem_instr !== 1'b0) begin n_fail++; $display("FAIL sim_store_first: got v %b i %b want 1 0", mem_valid, mem_instr); end
        n_checks++; if (mem_addr !== 32'h8000 || mem_wdata !== 32'hDEADBEEF || mem_wstrb !== 4'hF) begin n_fail++; $display("FAIL sim_store_attr: got %h %h %h", mem_addr, mem_wdata, mem_wstrb); end
        tick(); mem_ready = 1'b1;
        #1;
        n_checks++; if (dmem_ready !== 1'b1 || imem_ready !== 1'b0) begin n_fail++; $display("FAIL sim_store_resp: got d %b i %b want 1 0", dmem_ready, imem_ready); end
        tick(); #1;
        n_checks++; if (mem_valid !== 1'b1 || mem_instr !== 1'b1 || mem_addr !== 32'h200 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL sim_fetch_next: got v %b i %b a %h s %h", mem_valid, mem_instr, mem_addr, mem_wstrb); end
        tick(); mem_ready = 1'b1; mem_rdata = 32'h00000093;
        #1;
        n_checks++; if (imem_ready !== 1'b1 || imem_rdata !== 32'h93) begin n_fail++; $display("FAIL sim_fetch_resp: got %b %h want 1 00000093", imem_ready, imem_rdata); end
        tick();
    endtask

    task automatic test_burst_limit();
        bit [6:0]    exp_i = 7'b0010000;
        int          d_n = 0;
        logic [31:0] exp_addr;
        tick();
        imem_valid = 1'b1; imem_addr = 32'h400;
        dmem_valid = 1'b1; dmem_addr = 32'h1000; dmem_wdata = '0; dmem_wstrb = 4'h0;
        for (int t = 0; t < 7; t++) begin
            tick(); #1;
            exp_addr = exp_i[t] ? 32'h400 : 32'h1000 + 32'(4 * d_n);
            n_checks++; if (mem_valid !== 1'b1 || mem_instr !== exp_i[t]) begin n_fail++; $display("FAIL burst_order[%0d]: got v %b i %b want 1 %b", t, mem_valid, mem_instr, exp_i[t]); end
            n_checks++; if (mem_addr !== exp_addr) begin n_fail++; $display("FAIL burst_addr[%0d]: got %h want %h", t, mem_addr, exp_addr); end
            tick(); mem_ready = 1'b1; mem_rdata = 32'hA0 + 32'(t);
            if (!exp_i[t]) begin
                d_n++;
                if (d_n < 6) begin dmem_valid = 1'b1; dmem_addr = 32'h1000 + 32'(4 * d_n); end
            end
            #1;
            n_checks++; if (imem_ready !== exp_i[t] || dmem_ready !== !exp_i[t]) begin n_fail++; $display("FAIL burst_resp[%0d]: got i %b d %b", t, imem_ready, dmem_ready); end
        end
        tick(); #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL burst_drain: got %b want 0", mem_valid); end
    endtask

    task automatic test_flush();
        tick(); imem_valid = 1'b1; imem_addr = 32'h2F0;
        tick(); #1;
        n_checks++; if (mem_valid !== 1'b1 || mem_addr !== 32'h2F0) begin n_fail++; $display("FAIL flush_old_issue: got %b %h want 1 000002f0", mem_valid, mem_addr); end
        tick(); iflush = 1'b1;
        tick(); imem_valid = 1'b1; imem_addr = 32'h300;
        tick(); mem_ready = 1'b1; mem_rdata = 32'hBAD;
        #1;
        n_checks++; if (imem_ready !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got %b want 0", imem_ready); end
        tick(); #1;
        n_checks++; if (mem_valid !== 1'b1 || mem_instr !== 1'b1 || mem_addr !== 32'h300) begin n_fail++; $display("FAIL flush_new_issue: got v %b i %b a %h", mem_valid, mem_instr, mem_addr); end
        tick(); mem_ready = 1'b1; mem_rdata = 32'h55;
        #1;
        n_checks++; if (imem_ready !== 1'b1 || imem_rdata !== 32'h55) begin n_fail++; $display("FAIL flush_new_resp: got %b %h want 1 00000055", imem_ready, imem_rdata); end
        // Flush landing in the very cycle the fetch issues.
        tick(); imem_valid = 1'b1; imem_addr = 32'h500;
        tick(); iflush = 1'b1;
        tick(); mem_ready = 1'b1;
        #1;
        n_checks++; if (imem_ready !== 1'b0) begin n_fail++; $display("FAIL flush_at_issue: got %b want 0", imem_ready); end
        tick();
    endtask

    task automatic test_reset_mid();
        tick(); dmem_valid = 1'b1; dmem_addr = 32'h9000; dmem_wdata = 32'h12345678; dmem_wstrb = 4'h3;
        tick();
        rst = 1'b0;
        #1;
        n_checks++; if (mem_valid !== 1'b0 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL rstmid_abort: got v %b s %h want 0 0", mem_valid, mem_wstrb); end
        tick();
        rst = 1'b1; mem_ready = 1'b1;
        #1;
        n_checks++; if (dmem_ready !== 1'b0 || imem_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_stray: got d %b i %b want 0 0", dmem_ready, imem_ready); end
        tick(); imem_valid = 1'b1; imem_addr = 32'h0;
        #1;
        n_checks++; if (mem_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet: got %b want 0", mem_valid); end
        tick(); #1;
        n_checks++; if (mem_valid !== 1'b1 || mem_instr !== 1'b1 || mem_addr !== 32'h0) begin n_fail++; $display("FAIL rstmid_fetch: got v %b i %b a %h", mem_valid, mem_instr, mem_addr); end
        tick(); mem_ready = 1'b1; mem_rdata = 32'h17;
        #1;
        n_checks++; if (imem_ready !== 1'b1 || imem_rdata !== 32'h17) begin n_fail++; $display("FAIL rstmid_resp: got %b %h want 1 00000017", imem_ready, imem_rdata); end
        tick();
    endtask

    task automatic test_delayed_load();
        int nv = 0, nd = 0, ni = 0;
        tick(); dmem_valid = 1'b1; dmem_addr = 32'h8004; dmem_wstrb = 4'h0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 6) begin mem_ready = 1'b1; mem_rdata = 32'hCAFE0004; end
            #1;
            if (c == 1) begin
                n_checks++; if (mem_valid !== 1'b1 || mem_instr !== 1'b0 || mem_addr !== 32'h8004 || mem_wstrb !== 4'h0) begin n_fail++; $display("FAIL dly_issue: got v %b i %b a %h s %h", mem_valid, mem_instr, mem_addr, mem_wstrb); end
            end
            if (c == 6) begin
                n_checks++; if (dmem_ready !== 1'b1 || dmem_rdata !== 32'hCAFE0004) begin n_fail++; $display("FAIL dly_resp: got %b %h want 1 cafe0004", dmem_ready, dmem_rdata); end
            end
            if (mem_valid === 1'b1)  nv++;
            if (dmem_ready === 1'b1) nd++;
            if (imem_ready === 1'b1) ni++;
        end
        n_checks++; if (nv != 1) begin n_fail++; $display("FAIL dly_valid_count: got %0d want 1", nv); end
        n_checks++; if (nd != 1) begin n_fail++; $display("FAIL dly_ready_count: got %0d want 1", nd); end
        n_checks++; if (ni != 0) begin n_fail++; $display("FAIL dly_imem_untouched: got %0d want 0", ni); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_burst_limit();
        test_flush();
        test_reset_mid();
        test_delayed_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
